// File: rtl/logical_tile_io_bank_iopad.sv
// Purpose : GPIO bank of NUM_PADS pads configured from one serial config-chain segment,
//           with a shadow register so that pads only change on an explicit commit.
// Latency : chain shifts one bit per prog_clk; pads follow the shadow combinationally on the commit edge.
// Backpr. : none; ccff_en gates shifting and a commit on a short frame is refused and flagged in cfg_err.
// Ports   : prog_clk/pReset (async, active-high) | ccff_en, ccff_head, ccff_tail: serial chain
//           ccff_commit -> cfg_full (frame loaded), cfg_valid (sticky ok), cfg_err (sticky refused)
//           gfpga_pad_GPIO_PAD (inout pads), iopad_outpad (fabric->pad), iopad_inpad (pad->fabric)
// Option  : define IOPAD_CFG_PARITY_EN to add a leading even-parity bit to the chain frame.
// Per-pad config at chain[p*3+k]: k=0 DIR, k=1 OUT_INV, k=2 IN_INV.
module logical_tile_io_bank_iopad #(
  parameter int NUM_PADS = 4,
  parameter int CFG_BITS = 3
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  input  logic                ccff_commit,
  output logic                cfg_full,
  output logic                cfg_valid,
  output logic                cfg_err,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_PADS-1:0] iopad_outpad,
  output logic [NUM_PADS-1:0] iopad_inpad
);

  localparam int CHAIN_LEN = NUM_PADS * CFG_BITS;
`ifdef IOPAD_CFG_PARITY_EN
  localparam int CL = CHAIN_LEN + 1;   // parity bit sits at the top of the chain
`else
  localparam int CL = CHAIN_LEN;
`endif
  localparam int CW = $clog2(CHAIN_LEN + 2);

  if (CFG_BITS != 3) begin : g_bad_cfg_bits
    $error("logical_tile_io_bank_iopad: CFG_BITS must be 3");
  end
  if (NUM_PADS < 1 || NUM_PADS > 32) begin : g_bad_num_pads
    $error("logical_tile_io_bank_iopad: NUM_PADS must be 1..32");
  end

  logic [CL-1:0]        chain;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CW-1:0]        shift_cnt;
  logic                 commit_ok;

  assign cfg_full  = (shift_cnt == CW'(CL));
  assign ccff_tail = chain[CL-1];

`ifdef IOPAD_CFG_PARITY_EN
  // Whole frame including the parity bit must XOR to zero.
  assign commit_ok = cfg_full && !(^chain);
`else
  assign commit_ok = cfg_full;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain     <= '0;
      shadow    <= '0;
      shift_cnt <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (ccff_en) begin
        chain <= {chain[CL-2:0], ccff_head};
      end

      // A full-frame commit restarts the count (a parity failure still restarts it);
      // a concurrent shift is the first bit of the next frame.
      if (ccff_commit && cfg_full) begin
        shift_cnt <= ccff_en ? CW'(1) : '0;
      end else if (ccff_en && !cfg_full) begin
        shift_cnt <= shift_cnt + CW'(1);
      end

      // Shadow captures the pre-shift chain contents of this edge.
      if (ccff_commit && commit_ok) begin
        shadow    <= chain[CHAIN_LEN-1:0];
        cfg_valid <= 1'b1;
      end
      if (ccff_commit && !commit_ok) begin
        cfg_err <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic dir, out_inv, in_inv;
    assign dir     = shadow[p*3];
    assign out_inv = shadow[p*3+1];
    assign in_inv  = shadow[p*3+2];

    assign gfpga_pad_GPIO_PAD[p] = dir ? (iopad_outpad[p] ^ out_inv) : 1'bz;
    // Input path always reads the pad, so output mode loops back to the fabric.
    assign iopad_inpad[p]        = gfpga_pad_GPIO_PAD[p] ^ in_inv;
  end

endmodule
